// File: rtl/ram1k_access_ctrl.sv
// Burst read/write sequencer in front of the 1Kx8 RAM bank decoder: one Bank_En pulse per beat.
// Read data 3 cycles after acceptance (2 per beat); writes stall in WR_WAIT until Wr_Data_Valid, no Rd backpressure.
module ram1k_access_ctrl #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8,
    parameter int BANK_W = 3,
    parameter int LEN_W  = 4
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     Req_Valid,
    output logic                     Req_Ready,
    input  logic                     Req_Write,
    input  logic [ADDR_W-1:0]        Req_Addr,
    input  logic [LEN_W-1:0]         Req_Len,
    input  logic [DATA_W-1:0]        Wr_Data,
    input  logic                     Wr_Data_Valid,
    output logic                     Wr_Data_Ready,
    output logic [DATA_W-1:0]        Rd_Data,
    output logic                     Rd_Valid,
    output logic                     Busy,
    output logic [BANK_W-1:0]        Bank_Sel,
    output logic                     Bank_En,
    output logic [ADDR_W-BANK_W-1:0] Row_Addr,
    output logic                     Mem_WE,
    output logic [DATA_W-1:0]        Mem_Din,
    input  logic [DATA_W-1:0]        Mem_Dout
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ACC  = 3'd1,
        RD_CAP  = 3'd2,
        WR_WAIT = 3'd3,
        WR_ACC  = 3'd4
    } state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [ADDR_W-1:0]   addr_d;
    logic [LEN_W-1:0]    cnt_q;
    logic [DATA_W-1:0]   rd_data_q;
    logic                rd_vld_q;
    logic [DATA_W-1:0]   din_q;

    // Natural wrap of the adder gives the modulo-1K address sequence.
    assign addr_d        = addr_q + ADDR_W'(1);

    assign Req_Ready     = (state_q == IDLE) & ~RST;
    assign Busy          = (state_q != IDLE);
    assign Wr_Data_Ready = (state_q == WR_WAIT);
    assign Bank_En       = (state_q == RD_ACC) | (state_q == WR_ACC);
    assign Mem_WE        = (state_q == WR_ACC);
    assign Bank_Sel      = addr_q[ADDR_W-1 -: BANK_W];
    assign Row_Addr      = addr_q[ADDR_W-BANK_W-1:0];
    assign Rd_Data       = rd_data_q;
    assign Rd_Valid      = rd_vld_q;
    assign Mem_Din       = din_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            cnt_q     <= '0;
            rd_data_q <= '0;
            rd_vld_q  <= 1'b0;
            din_q     <= '0;
        end else begin
            rd_vld_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (Req_Valid) begin
                        addr_q  <= Req_Addr;
                        cnt_q   <= Req_Len;
                        state_q <= Req_Write ? WR_WAIT : RD_ACC;
                    end
                end
                RD_ACC: state_q <= RD_CAP;
                RD_CAP: begin
                    // Bank output is valid this cycle, one cycle after the enable.
                    rd_data_q <= Mem_Dout;
                    rd_vld_q  <= 1'b1;
                    addr_q    <= addr_d;
                    if (cnt_q == '0) begin
                        state_q <= IDLE;
                    end else begin
                        cnt_q   <= cnt_q - LEN_W'(1);
                        state_q <= RD_ACC;
                    end
                end
                WR_WAIT: begin
                    if (Wr_Data_Valid) begin
                        din_q   <= Wr_Data;
                        state_q <= WR_ACC;
                    end
                end
                WR_ACC: begin
                    addr_q <= addr_d;
                    if (cnt_q == '0) begin
                        state_q <= IDLE;
                    end else begin
                        cnt_q   <= cnt_q - LEN_W'(1);
                        state_q <= WR_WAIT;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
